costas_sync_monitor: RTL



---
 rtl/costas_sync_monitor.sv | 101 ++++++++++
 1 files changed

// File: rtl/costas_sync_monitor.sv
// costas_sync_monitor: measures the divider's divclk against ref_tick and pulses sync low to realign it.
module costas_sync_monitor #(
  parameter int EXP_PERIOD   = 1001,
  parameter int PHASE_TARGET = 3,
  parameter int PHASE_TOL    = 2,
  parameter int PERIOD_TOL   = 0,
  parameter int LOCK_CNT     = 4,
  parameter int SYNC_LEN     = 2,
  parameter int HOLDOFF      = 2048
) (
  input  logic        clockin,
  input  logic        resetn,
  input  logic        enable,
  input  logic        divclk,
  input  logic        ref_tick,
  output logic        sync,
  output logic        locked,
  output logic        meas_valid,
  output logic [31:0] period,
  output logic [31:0] high_time,
  output logic [31:0] phase_err
);
  localparam int CW = $clog2(HOLDOFF + SYNC_LEN + 1);
  localparam int GW = $clog2(LOCK_CNT + 1);
  typedef enum logic [2:0] {IDLE, ACQUIRE, TRACK, RESYNC, HOLD_OFF} state_t;
  state_t state, nxt;
  logic s1, s2, s3, armed, rise, fall, busy, seen, tol, tick_ok;
  logic [31:0] rise_cnt, hi_cnt, err_abs, per_abs;
  logic signed [31:0] raw, err, pdiff;
  logic [CW-1:0] cnt;
  logic [GW-1:0] good, good_nxt;
  assign rise = s2 & ~s3;
  assign fall = ~s2 & s3;
  assign busy = state == RESYNC || state == HOLD_OFF;
  assign seen = armed | rise;
  // phase is folded into (-period/2, period/2] so early ticks read as negative error
  assign raw = (rise ? 32'sd0 : $signed(rise_cnt)) - PHASE_TARGET;
  assign err = raw > $signed({1'b0, period[31:1]}) ? raw - $signed(period) : raw;
  assign err_abs = err[31] ? -err : err;
  assign pdiff = $signed(period) - EXP_PERIOD;
  assign per_abs = pdiff[31] ? -pdiff : pdiff;
  // a zero period means nothing measured yet, so only phase can be judged
  assign tol = err_abs <= 32'(PHASE_TOL) && (period == 32'd0 || per_abs <= 32'(PERIOD_TOL));
  assign tick_ok = seen & tol;
  always_comb begin
    nxt = state;
    good_nxt = good;
    case (state)
      IDLE: nxt = rise ? ACQUIRE : IDLE;
      ACQUIRE: if (ref_tick) begin
        good_nxt = good + 1'b1;
        nxt = !tick_ok ? RESYNC : good_nxt == GW'(LOCK_CNT) ? TRACK : ACQUIRE;
      end
      TRACK: nxt = ref_tick && !tick_ok ? RESYNC : TRACK;
      RESYNC: begin
        good_nxt = '0;
        nxt = cnt == CW'(SYNC_LEN - 1) ? HOLD_OFF : RESYNC;
      end
      HOLD_OFF: nxt = cnt == CW'(HOLDOFF - 1) ? ACQUIRE : HOLD_OFF;
      default: nxt = IDLE;
    endcase
    if (!enable) begin
      nxt = IDLE;
      good_nxt = '0;
    end
  end
  always_ff @(posedge clockin or negedge resetn)
    if (!resetn) begin
      s1 <= 1'b0;
      s2 <= 1'b0;
      s3 <= 1'b0;
      state <= IDLE;
      good <= '0;
      cnt <= '0;
      sync <= 1'b1;
      locked <= 1'b0;
      rise_cnt <= '0;
      hi_cnt <= '0;
      armed <= 1'b0;
      meas_valid <= 1'b0;
      period <= '0;
      high_time <= '0;
      phase_err <= '0;
    end else begin
      s1 <= divclk;
      s2 <= s1;
      s3 <= s2;
      state <= nxt;
      good <= good_nxt;
      cnt <= nxt != state ? '0 : cnt + 1'b1;
      sync <= nxt != RESYNC;
      locked <= nxt == TRACK;
      rise_cnt <= rise ? 32'd1 : &rise_cnt ? rise_cnt : rise_cnt + 1'b1;
      hi_cnt <= fall ? '0 : s2 ? hi_cnt + 1'b1 : hi_cnt;
      armed <= busy ? 1'b0 : armed | rise;
      meas_valid <= rise & armed & ~busy;
      if (rise && armed && !busy) period <= rise_cnt;
      if (fall && !busy) high_time <= hi_cnt;
      if (ref_tick && !busy) phase_err <= err;
    end
endmodule
